// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - AES-128/192/256 key expansion, one schedule word per cycle
// Round keys are read combinationally from the word store by round index.
module aes_key_schedule #(
  parameter int MAX_WORDS = 60,
  parameter int RK_IDX_W  = 4
) (
  input  logic                eph1,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          key_size,
  input  logic [255:0]        true_key,
  input  logic [7:0]          SBOX [256],
  input  logic [RK_IDX_W-1:0] rk_rd_idx,
  output logic [127:0]        rk_rd_data,
  output logic                rk_valid,
  output logic [RK_IDX_W-1:0] num_rounds,
  output logic                busy,
  output logic                key_done,
  output logic                key_err
);
  localparam int AW = $clog2(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          nk_m1_q, nk_m1_d;
  logic [AW-1:0]       last_q, last_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [2:0]          mod_q, mod_d;
  logic [7:0]          rcon_q, rcon_d;
  logic [RK_IDX_W-1:0] nr_q, nr_d;
  logic                err_q, err_d;
  logic [31:0]         w_q [MAX_WORDS];

  logic [AW-1:0] nk_w, prev_idx, far_idx, rd_base;
  logic [31:0]   prev, far, rot, sub_in, sub_out, t, wr_data;
  logic [7:0]    rcon_next;
  logic          rd_ok;

  assign nk_w     = AW'(nk_m1_q) + AW'(1);
  // Guarded indices keep reads in range while idle (idx_q may be below Nk).
  assign prev_idx = (idx_q == '0) ? '0 : idx_q - AW'(1);
  assign far_idx  = (idx_q >= nk_w) ? idx_q - nk_w : '0;
  assign prev     = w_q[prev_idx];
  assign far      = w_q[far_idx];
  assign rot      = {prev[23:0], prev[31:24]};
  assign sub_in   = (mod_q == 3'd0) ? rot : prev;
  assign sub_out  = {SBOX[sub_in[31:24]], SBOX[sub_in[23:16]],
                     SBOX[sub_in[15:8]], SBOX[sub_in[7:0]]};
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  always_comb begin
    t = prev;
    if (mod_q == 3'd0)
      t = sub_out ^ {rcon_q, 24'h0};
    else if (nk_m1_q == 3'd7 && mod_q == 3'd4)
      t = sub_out;
  end

  assign wr_data = far ^ t;

  always_comb begin
    state_d = state_q;
    nk_m1_d = nk_m1_q;
    last_d  = last_q;
    idx_d   = idx_q;
    mod_d   = mod_q;
    rcon_d  = rcon_q;
    nr_d    = nr_q;
    err_d   = err_q;
    if (start) begin
      if (key_size == 2'b11) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        state_d = LOAD;
        err_d   = 1'b0;
        case (key_size)
          2'b00:   begin nk_m1_d = 3'd3; last_d = AW'(43); nr_d = RK_IDX_W'(10); end
          2'b01:   begin nk_m1_d = 3'd5; last_d = AW'(51); nr_d = RK_IDX_W'(12); end
          default: begin nk_m1_d = 3'd7; last_d = AW'(59); nr_d = RK_IDX_W'(14); end
        endcase
      end
    end else begin
      case (state_q)
        LOAD: begin
          idx_d   = nk_w;
          mod_d   = 3'd0;
          rcon_d  = 8'h01;
          state_d = EXPAND;
        end
        EXPAND: begin
          mod_d = (mod_q == nk_m1_q) ? 3'd0 : mod_q + 3'd1;
          if (mod_q == 3'd0) rcon_d = rcon_next;
          if (idx_q == last_q) state_d = DONE;
          else idx_d = idx_q + AW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge eph1 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      nk_m1_q <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      mod_q   <= '0;
      rcon_q  <= '0;
      nr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nk_m1_q <= nk_m1_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      mod_q   <= mod_d;
      rcon_q  <= rcon_d;
      nr_q    <= nr_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge eph1 or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < MAX_WORDS; k++) w_q[k] <= '0;
    end else if (state_q == LOAD) begin
      for (int k = 0; k < 8; k++)
        if (k <= int'(nk_m1_q)) w_q[k] <= true_key[255-32*k -: 32];
    end else if (state_q == EXPAND) begin
      w_q[idx_q] <= wr_data;
    end
  end

  // num_rounds never exceeds 14, so an in-range index keeps base+3 inside the store.
  assign rd_ok   = (rk_rd_idx <= nr_q);
  assign rd_base = rd_ok ? AW'({rk_rd_idx, 2'b00}) : '0;
  assign rk_rd_data = rd_ok ? {w_q[rd_base], w_q[rd_base + AW'(1)],
                               w_q[rd_base + AW'(2)], w_q[rd_base + AW'(3)]} : 128'h0;

  assign busy       = (state_q == LOAD) || (state_q == EXPAND);
  assign key_done   = (state_q == DONE);
  assign rk_valid   = key_done & rd_ok;
  assign num_rounds = nr_q;
  assign key_err    = err_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - directed vector bench for aes_key_schedule
module tb_aes_key_schedule;
  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   key_size;
  logic [255:0] true_key;
  logic [7:0]   sbox [256];
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_rd_data;
  logic         rk_valid;
  logic [3:0]   num_rounds;
  logic         busy;
  logic         key_done;
  logic         key_err;

  int checks = 0;
  int errors = 0;

  aes_key_schedule #(.MAX_WORDS(60), .RK_IDX_W(4)) dut (
    .eph1(clk), .reset(reset), .start(start), .key_size(key_size),
    .true_key(true_key), .SBOX(sbox), .rk_rd_idx(rk_rd_idx),
    .rk_rd_data(rk_rd_data), .rk_valid(rk_valid), .num_rounds(num_rounds),
    .busy(busy), .key_done(key_done), .key_err(key_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct {
    string        name;
    logic [1:0]   ks;
    logic [255:0] key;
    int           lat;
    logic [3:0]   nr;
    logic [3:0]   idx;
    logic [127:0] rk;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_job(input logic [1:0] ks, input logic [255:0] key, output int lat);
    key_size = ks;
    true_key = key;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    while (!key_done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [7:0] inv;

    for (int i = 0; i < 256; i++) begin
      inv = 8'h00;
      for (int j = 1; j < 256; j++)
        if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
      sbox[i] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end

    vecs[0] = '{"k128_rk0",  2'b00, K128, 42, 4'd10, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[1] = '{"k128_rk1",  2'b00, K128, 42, 4'd10, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{"k192_rk0",  2'b01, K192, 48, 4'd12, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5};
    vecs[3] = '{"k192_rk12", 2'b01, K192, 48, 4'd12, 4'd12, 128'he98ba06f448c773c8ecc720401002202};
    vecs[4] = '{"k256_rk1",  2'b10, K256, 54, 4'd14, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4};
    vecs[5] = '{"k256_rk14", 2'b10, K256, 54, 4'd14, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e};
    vecs[6] = '{"k128_rk10", 2'b00, K128, 42, 4'd10, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    reset = 1'b1; start = 1'b0; key_size = 2'b00; true_key = '0; rk_rd_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_done", 128'(key_done), 128'h0);
    chk("rst_err", 128'(key_err), 128'h0);
    chk("rst_nr", 128'(num_rounds), 128'h0);
    chk("rst_valid", 128'(rk_valid), 128'h0);
    chk("rst_data", rk_rd_data, 128'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      rk_rd_idx = vecs[v].idx;
      run_job(vecs[v].ks, vecs[v].key, lat);
      chk({vecs[v].name, "_lat"}, 128'(lat), 128'(vecs[v].lat));
      chk({vecs[v].name, "_nr"}, 128'(num_rounds), 128'(vecs[v].nr));
      chk({vecs[v].name, "_valid"}, 128'(rk_valid), 128'h1);
      chk({vecs[v].name, "_busy"}, 128'(busy), 128'h0);
      chk({vecs[v].name, "_data"}, rk_rd_data, vecs[v].rk);
    end

    // Abort a 256-bit job partway through EXPAND and restart with the 128-bit key.
    key_size = 2'b10; true_key = K256; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    chk("restart_busy", 128'(busy), 128'h1);
    rk_rd_idx = 4'd10;
    run_job(2'b00, K128, lat);
    chk("restart_lat", 128'(lat), 128'd42);
    chk("restart_nr", 128'(num_rounds), 128'd10);
    chk("restart_rk10", rk_rd_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    rk_rd_idx = 4'd15; #1;
    chk("idx15_valid", 128'(rk_valid), 128'h0);
    chk("idx15_data", rk_rd_data, 128'h0);
    rk_rd_idx = 4'd11; #1;
    chk("idx11_valid", 128'(rk_valid), 128'h0);
    chk("idx11_data", rk_rd_data, 128'h0);
    rk_rd_idx = 4'd1;
    @(posedge clk); #1;

    key_size = 2'b00; true_key = K128; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("drop_done", 128'(key_done), 128'h0);
    chk("drop_busy", 128'(busy), 128'h1);
    lat = 0;
    while (!key_done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rerun_done", 128'(key_done), 128'h1);

    key_size = 2'b11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ill_err", 128'(key_err), 128'h1);
    chk("ill_busy", 128'(busy), 128'h0);
    chk("ill_done", 128'(key_done), 128'h0);
    chk("ill_valid", 128'(rk_valid), 128'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("ill_sticky", 128'(key_err), 128'h1);
    key_size = 2'b00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("legal_err_clr", 128'(key_err), 128'h0);
    chk("legal_busy", 128'(busy), 128'h1);

    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk("areset_busy", 128'(busy), 128'h0);
    chk("areset_done", 128'(key_done), 128'h0);
    chk("areset_nr", 128'(num_rounds), 128'h0);
    chk("areset_err", 128'(key_err), 128'h0);
    chk("areset_valid", 128'(rk_valid), 128'h0);
    chk("areset_data", rk_rd_data, 128'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
